// File: rtl/i8080_bus_ctrl.sv
// i8080 system bus controller: status latch/decode, per-cycle wait states and
// an N-channel prioritised interrupt controller that jams RST n during INTA.
module i8080_bus_ctrl #(
  parameter int unsigned XLEN     = 8,
  parameter int unsigned NUM_IRQ  = 8,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sync_i,
  input  logic               dbin_i,
  input  logic               inte_i,
  input  logic [XLEN-1:0]    data_in_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [XLEN-1:0]    status_o,
  output logic               mem_en_o,
  output logic               io_en_o,
  output logic               inta_o,
  output logic               ready_o,
  output logic               int_req_o,
  output logic [XLEN-1:0]    data_out_o,
  output logic               data_oe_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam int unsigned StInta = 0;
  localparam int unsigned StHlta = 3;
  localparam int unsigned StOut  = 4;
  localparam int unsigned StInp  = 6;

  logic [XLEN-1:0]    status_q, status_d;
  logic [3:0]         wait_q, wait_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic [2:0]         sel_q, sel_d;

  logic [NUM_IRQ-1:0] lowest;
  logic [2:0]         lowest_idx;
  logic               inta_sync;

  // Lowest-numbered pending channel wins; default 7 gives RST 7 for spurious INTA.
  always_comb begin
    lowest     = '0;
    lowest_idx = 3'd7;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lowest     = '0;
        lowest[i]  = 1'b1;
        lowest_idx = 3'(i);
      end
    end
  end

  assign inta_sync = sync_i & data_in_i[StInta];

  always_comb begin
    status_d = status_q;
    wait_d   = (wait_q != 4'd0) ? wait_q - 4'd1 : wait_q;
    sel_d    = sel_q;
    ack_d    = '0;
    if (sync_i) begin
      status_d = data_in_i;
      if (data_in_i[StInp] | data_in_i[StOut]) begin
        wait_d = 4'(IO_WAIT);
      end else if (data_in_i[StInta] | data_in_i[StHlta]) begin
        wait_d = 4'd0;
      end else begin
        wait_d = 4'(MEM_WAIT);
      end
    end
    if (inta_sync) begin
      sel_d = lowest_idx;
      ack_d = lowest;
    end
    // A new edge on the channel being acknowledged keeps it pending.
    pend_d = (pend_q & ~ack_d) | (irq_i & ~irq_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q <= '0;
      wait_q   <= '0;
      pend_q   <= '0;
      irq_q    <= '0;
      ack_q    <= '0;
      sel_q    <= '0;
    end else begin
      status_q <= status_d;
      wait_q   <= wait_d;
      pend_q   <= pend_d;
      irq_q    <= irq_i;
      ack_q    <= ack_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    status_o   = status_q;
    inta_o     = status_q[StInta];
    io_en_o    = status_q[StInp] | status_q[StOut];
    mem_en_o   = ~io_en_o & ~inta_o;
    ready_o    = (wait_q == 4'd0);
    int_req_o  = inte_i & (|pend_q);
    data_oe_o  = inta_o & dbin_i;
    irq_ack_o  = ack_q;
    data_out_o = '0;
    data_out_o[7:0] = 8'hC7 | {2'b00, sel_q, 3'b000};
  end

endmodule

// File: tb/tb_i8080_bus_ctrl.sv
// Directed bench for i8080_bus_ctrl with a cycle-level reference model and
// per-cycle output comparison.
module tb_i8080_bus_ctrl;
  localparam int MEMW = 0;
  localparam int IOW  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0, dbin = 1'b0, inte = 1'b0;
  logic [7:0] data_in = 8'h00, irq = 8'h00;
  logic [7:0] status, data_out, irq_ack;
  logic       mem_en, io_en, inta, ready, int_req, data_oe;

  int n_tests = 0;
  int n_fail  = 0;

  i8080_bus_ctrl #(.XLEN(8), .NUM_IRQ(8), .MEM_WAIT(MEMW), .IO_WAIT(IOW)) dut (
    .clk_i(clk), .rst_i(rst), .sync_i(sync), .dbin_i(dbin), .inte_i(inte),
    .data_in_i(data_in), .irq_i(irq), .status_o(status), .mem_en_o(mem_en),
    .io_en_o(io_en), .inta_o(inta), .ready_o(ready), .int_req_o(int_req),
    .data_out_o(data_out), .data_oe_o(data_oe), .irq_ack_o(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: bus cycle kind, wait cycles remaining, set of pending channels.
  logic [7:0] m_status;
  int         m_wait;
  bit         m_pend[8];
  logic [7:0] m_prev_irq;
  int         m_sel;
  int         m_ack_ch;  // -1: no acknowledge this cycle

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_status = 8'h00; m_wait = 0; m_prev_irq = 8'h00; m_sel = 0; m_ack_ch = -1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      bit found;
      m_ack_ch = -1;
      if (m_wait > 0) m_wait = m_wait - 1;
      if (sync) begin
        m_status = data_in;
        if (data_in[6] || data_in[4]) m_wait = IOW;
        else if (data_in[0] || data_in[3]) m_wait = 0;
        else m_wait = MEMW;
        if (data_in[0]) begin
          found = 1'b0;
          m_sel = 7;
          for (int i = 0; i < 8; i++) begin
            if (!found && m_pend[i]) begin
              found = 1'b1; m_sel = i; m_ack_ch = i; m_pend[i] = 1'b0;
            end
          end
        end
      end
      for (int i = 0; i < 8; i++) if (irq[i] && !m_prev_irq[i]) m_pend[i] = 1'b1;
      m_prev_irq = irq;
    end
  end

  function automatic bit m_any_pend();
    foreach (m_pend[i]) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      logic [7:0] exp_ack;
      bit is_io, is_inta;
      exp_ack = (m_ack_ch >= 0) ? 8'(1 << m_ack_ch) : 8'h00;
      is_io   = m_status[6] || m_status[4];
      is_inta = m_status[0];
      chk("status",   status,   m_status);
      chk("inta",     inta,     is_inta);
      chk("io_en",    io_en,    is_io);
      chk("mem_en",   mem_en,   !is_io && !is_inta);
      chk("ready",    ready,    m_wait == 0);
      chk("int_req",  int_req,  inte && m_any_pend());
      chk("data_oe",  data_oe,  is_inta && dbin);
      chk("data_out", data_out, 8'hC7 + 8'(m_sel * 8));
      chk("irq_ack",  irq_ack,  exp_ack);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_sync(input logic [7:0] st);
    sync = 1'b1; data_in = st;
    tick();
    sync = 1'b0; data_in = 8'h00;
  endtask

  initial begin
    int lows;
    tick(); tick();
    rst = 1'b0;
    inte = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_mem_en", mem_en, 1'b1);
    chk("rst_data_out", data_out, 8'hC7);
    chk("rst_int_req", int_req, 1'b0);

    // Memory read, no wait states.
    tick();
    bus_sync(8'hA2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("memrd_ready", ready, 1'b1);
      chk("memrd_mem_en", mem_en, 1'b1);
      chk("memrd_io_en", io_en, 1'b0);
    end

    // OUT cycle with three wait states.
    tick();
    bus_sync(8'h10);
    lows = 0;
    @(negedge clk);
    chk("out_first_low", ready, 1'b0);
    chk("out_io_en", io_en, 1'b1);
    if (!ready) lows++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!ready) lows++;
    end
    chk("out_wait_count", lows, 3);

    // Priority: channels 5 and 2 together.
    tick();
    irq = 8'h24;
    tick(); tick();
    @(negedge clk);
    chk("prio_int_req", int_req, 1'b1);
    tick();
    bus_sync(8'h23);
    dbin = 1'b1;
    @(negedge clk);
    chk("prio_ack1", irq_ack, 8'h04);
    chk("prio_op1", data_out, 8'hD7);
    chk("prio_oe", data_oe, 1'b1);
    tick();
    dbin = 1'b0;
    @(negedge clk);
    chk("prio_ack1_gone", irq_ack, 8'h00);
    chk("prio_int_req_still", int_req, 1'b1);
    tick();
    bus_sync(8'h23);
    @(negedge clk);
    chk("prio_ack2", irq_ack, 8'h20);
    chk("prio_op2", data_out, 8'hEF);
    chk("prio_held_no_rereq", int_req, 1'b0);

    // Spurious INTA.
    tick();
    bus_sync(8'h23);
    dbin = 1'b1;
    @(negedge clk);
    chk("spur_op", data_out, 8'hFF);
    chk("spur_ack", irq_ack, 8'h00);
    chk("spur_oe_hi", data_oe, 1'b1);
    dbin = 1'b0;
    #1;
    chk("spur_oe_lo", data_oe, 1'b0);

    // Set/clear collision on channel 0.
    tick();
    irq = 8'h00; tick();
    irq = 8'h01; tick();
    irq = 8'h00; tick();
    irq = 8'h01;
    bus_sync(8'h23);
    @(negedge clk);
    chk("coll_ack", irq_ack, 8'h01);
    chk("coll_pending", int_req, 1'b1);
    inte = 1'b0;
    #1;
    chk("coll_masked", int_req, 1'b0);
    inte = 1'b1;

    // Async reset mid-wait with channels 0 and 2 pending.
    tick();
    irq = 8'h00; tick();
    irq = 8'h05; tick(); tick();
    bus_sync(8'h10);
    @(negedge clk);
    chk("prerst_ready", ready, 1'b0);
    #2;
    rst = 1'b1; irq = 8'h00;
    #1;
    chk("arst_ready", ready, 1'b1);
    chk("arst_int_req", int_req, 1'b0);
    chk("arst_mem_en", mem_en, 1'b1);
    chk("arst_data_out", data_out, 8'hC7);
    tick(); tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("postrst_no_pend", int_req, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i8080_bus_ctrl.md
# i8080_bus_ctrl

Parametrised bus controller for i8080-based systems. It latches the status word broadcast during `sync` and decodes it into memory, I/O and interrupt-acknowledge enables. It also inserts per-cycle-type wait states through `ready` and acts as an N-channel prioritised interrupt controller that jams an `RST n` opcode onto the bus during INTA reads. It sits between the `i8080` core and the RAM and peripherals in system tops.

## Interface
- `XLEN`, 8: data width; must be ≥ 8; opcode occupies bits [7:0], upper bits driven 0
- `NUM_IRQ`, 8: interrupt channels, 1..8; channel 0 highest priority
- `MEM_WAIT`, 0: wait states inserted on memory cycles, 0..15
- `IO_WAIT`, 1: wait states inserted on INP/OUT cycles, 0..15
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `sync`  in  1  CPU sync; status word valid on `data_in`
- `dbin`  in  1  CPU data-bus-in strobe
- `inte`  in  1  CPU interrupt-enable flag
- `data_in`  in  XLEN  CPU data bus as seen by controller
- `irq`  in  NUM_IRQ  interrupt request lines, active-high
- `status`  out  XLEN  latched status word
- `mem_en`  out  1  memory cycle in progress
- `io_en`  out  1  INP or OUT cycle in progress
- `inta`  out  1  interrupt-acknowledge cycle in progress
- `ready`  out  1  to CPU; low inserts wait state
- `int_req`  out  1  to CPU interrupt input
- `data_out`  out  XLEN  RST opcode for INTA read
- `data_oe`  out  1  drive `data_out` onto bus
- `irq_ack`  out  NUM_IRQ  one-hot, one-cycle acknowledge pulse

## Operation
- Status bits follow `i8080.vh`: INTA=0, HLTA=3, OUT=4, M1=5, INP=6.
- Status latch: on a rising edge with `sync`=1, `status` ← `data_in`; it holds otherwise.
- Decode is combinational from `status`:
  - `inta` = status[INTA]
  - `io_en` = status[INP] | status[OUT]
  - `mem_en` = ~`io_en` & ~`inta`
- Wait counter (4 bits), loaded at the `sync` edge from the incoming `data_in`:
  - IO_WAIT if INP|OUT
  - 0 if INTA or HLTA
  - MEM_WAIT otherwise
  - On each later edge it decrements while nonzero.
  - `ready` = (counter == 0).
- Interrupt pending register (NUM_IRQ bits):
  - Each bit is set on a rising edge of its `irq` line, detected against a registered copy `irq_q`.
  - Pending bits are edge-latched; a held-high line requests once.
- `int_req` = `inte` & |pending.
- Acknowledge, at a `sync` edge whose `data_in` has INTA set:
  - `sel` ← index of the lowest set pending bit; that bit is cleared.
  - `irq_ack[sel]` pulses for the following cycle.
  - If nothing is pending, `sel` ← 7, no ack pulse, and the bit is left alone.
- `data_out` = 8'hC7 | (`sel` << 3), i.e. `RST sel`, zero-extended.
- `data_oe` = `inta` & `dbin`.
- Set and clear of the same bit at the same edge: set wins, so the bit stays pending.
- Reset, including mid-cycle:
  - `status`, counter, pending, `irq_q`, `sel` and `irq_ack` all go to 0.
  - Result: `ready`=1, `mem_en`=1, `io_en`=0, `inta`=0, `int_req`=0, `data_oe`=0, `data_out`=8'hC7.

## Timing
- Status-to-enable latency: one edge. Enables are valid the cycle after the `sync` cycle and persist until the next `sync` edge.
- A cycle with N wait states drives `ready` low for exactly N clocks, starting the clock after `sync`. With N=0, `ready` never drops.
- Wait count is sampled only at `sync`; a new `sync` reloads the counter even if it is nonzero.
- `irq` rising edge → pending at the next edge → `int_req` combinationally high in that same cycle, if `inte`=1.
- `inte` low masks `int_req` only; pending bits are retained.
- `irq_ack` is high for exactly one cycle, the cycle after the INTA `sync`. `data_out` is stable from that cycle until the next INTA `sync`.

## Test plan
- Reset:
  - Stimulus: assert `rst` asynchronously mid-wait-state, with pending = 8'b0000_0101.
  - Required: `ready`=1, `int_req`=0 and pending = 0 immediately, without waiting for a clock edge.
- Memory read:
  - Stimulus: `sync` with `data_in`=8'hA2 and MEM_WAIT=0.
  - Required: `mem_en`=1, `io_en`=0, `ready` never low.
- I/O output:
  - Stimulus: `sync` with `data_in`=8'h10 and IO_WAIT=3.
  - Required: `io_en`=1; `ready` low for exactly 3 clocks, then high.
- Interrupt priority:
  - Stimulus: raise `irq`[5] and `irq`[2] together with `inte`=1, then an INTA `sync` (`data_in`=8'h23).
  - Required: `irq_ack`=8'h04 for one cycle; `data_out`=8'hD7.
  - Then: `int_req` stays 1; a second INTA yields 8'hEF and `irq_ack`=8'h20.
- Spurious INTA:
  - Stimulus: an INTA `sync` with pending = 0.
  - Required: `data_out`=8'hFF, `irq_ack`=0; `data_oe` follows `dbin`.
- Set/clear collision:
  - Stimulus: `irq`[0] rises on the same edge as an INTA `sync` that acknowledges channel 0.
  - Required: ack pulse on bit 0, and pending[0] remains 1.
